// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single ROB writeback port (CDB) between NUM_REQ functional units.
// Optional macro CDB_BYPASS_EN lets a request arriving at an empty buffer compete in the same cycle.
module cdb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int DATA_W    = 32,
  parameter int ROB_TAG_W = 5,
  parameter int ROB_SIZE  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         in_flush,
  input  logic [NUM_REQ-1:0]           in_req_valid,
  input  logic [NUM_REQ*ROB_TAG_W-1:0] in_req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]    in_req_value,
  output logic [NUM_REQ-1:0]           out_req_ready,
  output logic [ROB_TAG_W-1:0]         out_cdb_reorder,
  output logic [DATA_W-1:0]            out_cdb_value,
  output logic [1:0]                   out_cdb_src
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ROB_TAG_W-1:0] SENTINEL = ROB_TAG_W'(ROB_SIZE);

  // Handshake: a transfer on requester i happens at a posedge where
  // in_req_valid[i] && out_req_ready[i]; requesters hold tag/value until then.
  logic [NUM_REQ-1:0]   buf_valid;
  logic [ROB_TAG_W-1:0] buf_tag   [NUM_REQ];
  logic [DATA_W-1:0]    buf_value [NUM_REQ];
  logic [PTR_W-1:0]     ptr;

  logic                 advance;
  logic [NUM_REQ-1:0]   byp;
  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   grant;
  logic                 found;
  logic [PTR_W-1:0]     win;
  logic [ROB_TAG_W-1:0] win_tag;
  logic [DATA_W-1:0]    win_value;

  assign advance = rdy && !in_flush;

  // Bypass candidates: empty buffer receiving a non-sentinel transfer this cycle.
  always_comb begin
    byp = '0;
`ifdef CDB_BYPASS_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      byp[i] = advance && !buf_valid[i] && in_req_valid[i] &&
               (in_req_tag[i*ROB_TAG_W +: ROB_TAG_W] != SENTINEL);
    end
`endif
    cand = buf_valid | byp;
  end

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
    if (found) grant[win] = 1'b1;
  end

  // A granted empty buffer can only mean the bypassed incoming request won.
  always_comb begin
    if (buf_valid[win]) begin
      win_tag   = buf_tag[win];
      win_value = buf_value[win];
    end else begin
      win_tag   = in_req_tag[int'(win)*ROB_TAG_W +: ROB_TAG_W];
      win_value = in_req_value[int'(win)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      out_req_ready[i] = advance && (!buf_valid[i] || grant[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid       <= '0;
      ptr             <= '0;
      out_cdb_reorder <= SENTINEL;
      out_cdb_value   <= '0;
      out_cdb_src     <= '0;
    end else if (rdy) begin
      if (in_flush) begin
        buf_valid       <= '0;
        ptr             <= '0;
        out_cdb_reorder <= SENTINEL;
      end else begin
        if (found) begin
          out_cdb_reorder <= win_tag;
          out_cdb_value   <= win_value;
          out_cdb_src     <= 2'(win);
          ptr             <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
        end else begin
          out_cdb_reorder <= SENTINEL;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (in_req_valid[i] && out_req_ready[i]) begin
            // Sentinel tags are swallowed; a bypassed winner never lands in the buffer.
            buf_valid[i] <= (in_req_tag[i*ROB_TAG_W +: ROB_TAG_W] != SENTINEL) &&
                            !(byp[i] && grant[i]);
            buf_tag[i]   <= in_req_tag[i*ROB_TAG_W +: ROB_TAG_W];
            buf_value[i] <= in_req_value[i*DATA_W +: DATA_W];
          end else if (grant[i]) begin
            buf_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-cycle vector table plus hand-written
// latency and reset-mid-operation sequences.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_flush;
  logic [2:0]  in_req_valid;
  logic [14:0] in_req_tag;
  logic [95:0] in_req_value;
  logic [2:0]  out_req_ready;
  logic [4:0]  out_cdb_reorder;
  logic [31:0] out_cdb_value;
  logic [1:0]  out_cdb_src;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  cdb_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .in_flush        (in_flush),
    .in_req_valid    (in_req_valid),
    .in_req_tag      (in_req_tag),
    .in_req_value    (in_req_value),
    .out_req_ready   (out_req_ready),
    .out_cdb_reorder (out_cdb_reorder),
    .out_cdb_value   (out_cdb_value),
    .out_cdb_src     (out_cdb_src)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rdy;
    logic        flush;
    logic [2:0]  valid;
    logic [4:0]  t0, t1, t2;
    logic [31:0] v0, v1, v2;
    logic [2:0]  e_ready;
    logic [4:0]  e_tag;
    logic [31:0] e_val;
    logic [1:0]  e_src;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic f, input logic [2:0] va,
                              input logic [4:0] t0, input logic [31:0] v0,
                              input logic [4:0] t1, input logic [31:0] v1,
                              input logic [4:0] t2, input logic [31:0] v2,
                              input logic [2:0] er, input logic [4:0] et,
                              input logic [31:0] ev, input logic [1:0] es);
    vec_t v;
    v.rdy = r; v.flush = f; v.valid = va;
    v.t0 = t0; v.t1 = t1; v.t2 = t2;
    v.v0 = v0; v.v1 = v1; v.v2 = v2;
    v.e_ready = er; v.e_tag = et; v.e_val = ev; v.e_src = es;
    return v;
  endfunction

  task automatic check(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, row, act, exp);
    end
  endtask

  task automatic apply_row(input vec_t v, input int n);
    @(negedge clk);
    rdy          = v.rdy;
    in_flush     = v.flush;
    in_req_valid = v.valid;
    in_req_tag   = {v.t2, v.t1, v.t0};
    in_req_value = {v.v2, v.v1, v.v0};
    #1;
    check("ready", n, 32'(out_req_ready), 32'(v.e_ready));
    @(posedge clk);
    #1;
    check("cdb_tag", n, 32'(out_cdb_reorder), 32'(v.e_tag));
    check("cdb_value", n, out_cdb_value, v.e_val);
    check("cdb_src", n, 32'(out_cdb_src), 32'(v.e_src));
  endtask

  task automatic idle_inputs();
    rdy          = 1'b1;
    in_flush     = 1'b0;
    in_req_valid = '0;
    in_req_tag   = '0;
    in_req_value = '0;
  endtask

`ifdef CDB_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  initial begin
    int  seen_at;
    logic [4:0] e;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_tag", 0, 32'(out_cdb_reorder), 32'd16);
    check("reset_value", 0, out_cdb_value, 32'h0);
    check("reset_src", 0, 32'(out_cdb_src), 32'd0);
    check("reset_ready", 0, 32'(out_req_ready), 32'b111);
    @(negedge clk);
    rst = 1'b0;

    // single ALU request
    vecs.push_back(mk(1,0,3'b001, 3,'h11, 0,0, 0,0, 3'b111, 16,'h0,0));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 3,'h11,0));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 16,'h11,0));
    // flush to park pointer at 0, then three simultaneous requests
    vecs.push_back(mk(1,1,3'b000, 0,0, 0,0, 0,0, 3'b000, 16,'h11,0));
    vecs.push_back(mk(1,0,3'b111, 1,'hA1, 2,'hA2, 3,'hA3, 3'b111, 16,'h11,0));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b001, 1,'hA1,0));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b011, 2,'hA2,1));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 3,'hA3,2));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 16,'hA3,2));
    // ALU streams 4,5,6 against LSB tag 7
    vecs.push_back(mk(1,0,3'b011, 4,'hB4, 7,'hB7, 0,0, 3'b111, 16,'hA3,2));
    vecs.push_back(mk(1,0,3'b001, 5,'hB5, 0,0, 0,0, 3'b101, 4,'hB4,0));
    vecs.push_back(mk(1,0,3'b001, 6,'hB6, 0,0, 0,0, 3'b110, 7,'hB7,1));
    vecs.push_back(mk(1,0,3'b001, 6,'hB6, 0,0, 0,0, 3'b111, 5,'hB5,0));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 6,'hB6,0));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 16,'hB6,0));
    // flush with two occupied buffers
    vecs.push_back(mk(1,0,3'b011, 8,'hC8, 9,'hC9, 0,0, 3'b111, 16,'hB6,0));
    vecs.push_back(mk(1,1,3'b000, 0,0, 0,0, 0,0, 3'b000, 16,'hB6,0));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 16,'hB6,0));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 16,'hB6,0));
    // rdy stall for three cycles, ALU waiting with tag 12
    vecs.push_back(mk(1,0,3'b110, 0,0, 10,'hDA, 11,'hDB, 3'b111, 16,'hB6,0));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b011, 10,'hDA,1));
    vecs.push_back(mk(0,0,3'b001, 12,'hEE, 0,0, 0,0, 3'b000, 10,'hDA,1));
    vecs.push_back(mk(0,0,3'b001, 12,'hEE, 0,0, 0,0, 3'b000, 10,'hDA,1));
    vecs.push_back(mk(0,0,3'b001, 12,'hEE, 0,0, 0,0, 3'b000, 10,'hDA,1));
    vecs.push_back(mk(1,0,3'b001, 12,'hEE, 0,0, 0,0, 3'b111, 11,'hDB,2));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 12,'hEE,0));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 16,'hEE,0));
    // sentinel tag from branch unit, then a real branch result
    vecs.push_back(mk(1,0,3'b100, 0,0, 0,0, 16,'hFF, 3'b111, 16,'hEE,0));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 16,'hEE,0));
    vecs.push_back(mk(1,0,3'b100, 0,0, 0,0, 13,'h5D, 3'b111, 16,'hEE,0));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 13,'h5D,2));
    vecs.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 16,'h5D,2));

    for (int i = 0; i < vecs.size(); i++) apply_row(vecs[i], i + 1);

    // Latency: LSB request accepted at edge 1, result visible after edge EXP_LAT.
    @(negedge clk);
    idle_inputs();
    in_req_valid = 3'b010;
    in_req_tag   = {5'd0, 5'd15, 5'd0};
    in_req_value = {32'h0, 32'h1234, 32'h0};
    exp_q.push_back(5'd15);
    #1;
    check("lat_ready", 100, 32'(out_req_ready[1]), 32'd1);
    seen_at = 0;
    for (int k = 1; k <= 8 && seen_at == 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) in_req_valid = '0;
      if (out_cdb_reorder != 5'd16) begin
        seen_at = k;
        e = exp_q.pop_front();
        check("lat_tag", 101, 32'(out_cdb_reorder), 32'(e));
        check("lat_value", 101, out_cdb_value, 32'h1234);
        check("lat_edges", 101, 32'(k), 32'(EXP_LAT));
      end
    end
    if (seen_at == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL lat_timeout: no broadcast within 8 cycles, expected tag 15");
    end

    // Reset mid-operation discards the buffered result and the pointer.
    @(negedge clk);
    in_req_valid = 3'b001;
    in_req_tag   = {5'd0, 5'd0, 5'd14};
    in_req_value = {32'h0, 32'h0, 32'h77};
    @(posedge clk);
    #1;
    in_req_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_tag", 200, 32'(out_cdb_reorder), 32'd16);
    check("rst_mid_value", 200, out_cdb_value, 32'h0);
    check("rst_mid_src", 200, 32'(out_cdb_src), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("rst_mid_quiet", 201 + k, 32'(out_cdb_reorder), 32'd16);
    end

    // Pointer back at 0: LSB (tag 1) must win before branch (tag 2).
    @(negedge clk);
    in_req_valid = 3'b110;
    in_req_tag   = {5'd2, 5'd1, 5'd0};
    in_req_value = {32'h32, 32'h31, 32'h0};
    exp_q.push_back(5'd1);
    exp_q.push_back(5'd2);
    @(posedge clk);
    #1;
    in_req_valid = '0;
    if (out_cdb_reorder != 5'd16) begin
      e = exp_q.pop_front();
      check("order_tag", 300, 32'(out_cdb_reorder), 32'(e));
      check("order_src", 300, 32'(out_cdb_src), 32'(e));
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (out_cdb_reorder != 5'd16) begin
        if (exp_q.size() == 0) begin
          check("order_extra", 301 + k, 32'(out_cdb_reorder), 32'd16);
        end else begin
          e = exp_q.pop_front();
          check("order_tag", 301 + k, 32'(out_cdb_reorder), 32'(e));
          check("order_src", 301 + k, 32'(out_cdb_src), 32'(e));
        end
      end
    end
    check("order_drained", 310, 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
